// File: rtl/gpout_router.sv
// gpout_router: routes selectable sources to per-channel outputs through synchronised
// select/mode, four output modes (pass/reg/sticky/stretch) and change blanking.
module gpout_router #(
  parameter int CHANNELS     = 3,
  parameter int NSRC         = 16,
  parameter int SYNC_DEPTH   = 2,
  parameter int BLANK_CYCLES = 2,
  parameter int STRETCH_LEN  = 8,
  localparam int SEL_W       = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NSRC-1:0]           i_src,
  input  logic [CHANNELS*SEL_W-1:0] i_sel,
  input  logic [CHANNELS*2-1:0]     i_mode,
  input  logic [CHANNELS-1:0]       i_clr,
  output logic [CHANNELS-1:0]       o_gpout,
  output logic [CHANNELS-1:0]       o_blank
);
  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam int STR_W   = $clog2(STRETCH_LEN + 1);
  localparam logic [1:0] M_PASS    = 2'd0;
  localparam logic [1:0] M_REG     = 2'd1;
  localparam logic [1:0] M_STICKY  = 2'd2;
  localparam logic [1:0] M_STRETCH = 2'd3;
  // Zero-padded to the full select range so out-of-range selects read 0.
  logic [(1<<SEL_W)-1:0] src_pad;
  always_comb begin
    src_pad = '0;
    src_pad[NSRC-1:0] = i_src;
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_DEPTH-1:0][SEL_W-1:0] sel_sync_q;
    logic [SYNC_DEPTH-1:0][1:0]       mode_sync_q;
    logic [SEL_W-1:0]                 ssel, prev_sel_q;
    logic [1:0]                       smode, prev_mode_q;
    logic [BLANK_W-1:0]               blank_q, blank_d;
    logic [STR_W-1:0]                 str_q, str_d;
    logic reg_q, reg_d, sticky_q, sticky_d, prev_s_q;
    logic s, rise, changed, blanking, mode_out;
    assign ssel  = sel_sync_q[SYNC_DEPTH-1];
    assign smode = mode_sync_q[SYNC_DEPTH-1];
    always_comb begin
      s        = src_pad[ssel];
      rise     = s && !prev_s_q;
      changed  = (ssel != prev_sel_q) || (smode != prev_mode_q);
      blanking = blank_q != '0;
      blank_d  = changed ? BLANK_W'(BLANK_CYCLES) : blanking ? blank_q - 1'b1 : '0;
      reg_d    = !blanking && smode == M_REG && s;
      sticky_d = !blanking && smode == M_STICKY && (s || (sticky_q && !i_clr[c]));
      str_d    = (blanking || smode != M_STRETCH) ? '0 :
                 rise ? STR_W'(STRETCH_LEN) :
                 (str_q != '0) ? str_q - 1'b1 : '0;
      mode_out = (smode == M_PASS) ? s :
                 (smode == M_REG) ? reg_q :
                 (smode == M_STICKY) ? sticky_q : (str_q != '0);
    end
    // prev_s_q tracks s even while blanking so no false edge appears afterwards.
    always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
        sel_sync_q  <= '0;
        mode_sync_q <= '0;
        prev_sel_q  <= '0;
        prev_mode_q <= '0;
        blank_q     <= '0;
        str_q       <= '0;
        reg_q       <= 1'b0;
        sticky_q    <= 1'b0;
        prev_s_q    <= 1'b0;
      end else begin
        sel_sync_q  <= {sel_sync_q[SYNC_DEPTH-2:0], i_sel[c*SEL_W +: SEL_W]};
        mode_sync_q <= {mode_sync_q[SYNC_DEPTH-2:0], i_mode[c*2 +: 2]};
        prev_sel_q  <= ssel;
        prev_mode_q <= smode;
        blank_q     <= blank_d;
        str_q       <= str_d;
        reg_q       <= reg_d;
        sticky_q    <= sticky_d;
        prev_s_q    <= s;
      end
    end
    assign o_gpout[c] = i_reset_n && !blanking && mode_out;
    assign o_blank[c] = i_reset_n && blanking;
  end
endmodule

// File: tb/tb_gpout_router.sv
// tb_gpout_router: directed and randomized stimulus; expected outputs come from a
// cycle-history model of the routing rules and are checked by a queue-based monitor.
module tb_gpout_router;
  localparam int CH = 3, NSRC = 12, SEL_W = 4, SD = 2, BL = 2, SL = 8, MAXC = 4000;
  typedef struct packed { int n; logic [CH-1:0] g; logic [CH-1:0] b; } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NSRC-1:0] src = '0;
  logic [CH*SEL_W-1:0] sel = '0;
  logic [CH*2-1:0] mode = '0;
  logic [CH-1:0] clr = '0;
  logic [CH-1:0] gpout, blank;
  logic [NSRC-1:0] n_src = '0;
  logic [CH*SEL_W-1:0] n_sel = '0;
  logic [CH*2-1:0] n_mode = '0;
  logic [CH-1:0] n_clr = '0;
  logic n_rst_n = 1'b0;
  logic [NSRC-1:0] src_h [MAXC];
  logic [CH*SEL_W-1:0] sel_h [MAXC];
  logic [CH*2-1:0] mode_h [MAXC];
  logic [CH-1:0] clr_h [MAXC];
  bit rst_h [MAXC];
  int ssel_m [MAXC][CH];
  int smode_m [MAXC][CH];
  bit s_m [MAXC][CH];
  bit blank_m [MAXC][CH];
  exp_t exp_q[$];
  exp_t mon_e;
  int cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  gpout_router #(.CHANNELS(CH), .NSRC(NSRC), .SYNC_DEPTH(SD), .BLANK_CYCLES(BL),
                 .STRETCH_LEN(SL)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_src(src), .i_sel(sel), .i_mode(mode),
    .i_clr(clr), .o_gpout(gpout), .o_blank(blank));
  function automatic bit in_rst(int k);
    if (k < 0) return 1'b1;
    return rst_h[k];
  endfunction
  // Synchronised value: input from SD cycles ago unless a reset hit the chain since.
  function automatic int sync_val(int n, int c, bit is_mode);
    for (int k = n - SD; k < n; k++) if (in_rst(k)) return 0;
    if (is_mode) return int'(mode_h[n-SD][c*2 +: 2]);
    return int'(sel_h[n-SD][c*SEL_W +: SEL_W]);
  endfunction
  function automatic bit changed(int m, int c);
    if (in_rst(m - 1)) return ssel_m[m][c] != 0 || smode_m[m][c] != 0;
    return ssel_m[m][c] != ssel_m[m-1][c] || smode_m[m][c] != smode_m[m-1][c];
  endfunction
  // Blanked if any unreset change happened in the previous BL cycles.
  function automatic bit blank_at(int n, int c);
    for (int m = n - 1; m >= n - BL; m--) begin
      if (in_rst(m)) return 1'b0;
      if (changed(m, c)) return 1'b1;
    end
    return 1'b0;
  endfunction
  function automatic bit live(int k, int c, int md);
    if (in_rst(k)) return 1'b0;
    return !blank_m[k][c] && smode_m[k][c] == md;
  endfunction
  function automatic bit sprev(int k, int c);
    if (in_rst(k - 1)) return 1'b0;
    return s_m[k-1][c];
  endfunction
  function automatic bit mode_out(int n, int c);
    case (smode_m[n][c])
      0: return s_m[n][c];
      1: begin
        if (live(n - 1, c, 1)) return s_m[n-1][c];
        return 1'b0;
      end
      2: begin
        for (int k = n - 1; k >= 0; k--) begin
          if (!live(k, c, 2)) return 1'b0;
          if (s_m[k][c]) return 1'b1;
          if (clr_h[k][c]) return 1'b0;
        end
        return 1'b0;
      end
      default: begin
        for (int k = n - 1; k >= n - SL; k--) begin
          if (!live(k, c, 3)) return 1'b0;
          if (s_m[k][c] && !sprev(k, c)) return 1'b1;
        end
        return 1'b0;
      end
    endcase
  endfunction
  task automatic record();
    exp_t e;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget reached=%0d allowed=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    src_h[cyc] = src; sel_h[cyc] = sel; mode_h[cyc] = mode; clr_h[cyc] = clr;
    rst_h[cyc] = !rst_n;
    e.n = cyc;
    for (int c = 0; c < CH; c++) begin
      ssel_m[cyc][c]  = sync_val(cyc, c, 1'b0);
      smode_m[cyc][c] = sync_val(cyc, c, 1'b1);
      s_m[cyc][c]     = (ssel_m[cyc][c] < NSRC) ? src[ssel_m[cyc][c]] : 1'b0;
      blank_m[cyc][c] = blank_at(cyc, c);
      e.g[c] = !rst_h[cyc] && !blank_m[cyc][c] && mode_out(cyc, c);
      e.b[c] = !rst_h[cyc] && blank_m[cyc][c];
    end
    exp_q.push_back(e);
    cyc++;
  endtask
  task automatic drive(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      src = n_src; sel = n_sel; mode = n_mode; clr = n_clr; rst_n = n_rst_n;
      record();
    end
  endtask
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (gpout !== mon_e.g || blank !== mon_e.b) begin
        errors++;
        $display("FAIL outputs cyc=%0d got gpout=%b blank=%b required gpout=%b blank=%b",
                 mon_e.n, gpout, blank, mon_e.g, mon_e.b);
      end
    end
  end
  initial begin
    drive(4);
    n_rst_n = 1'b1;
    drive(6);
    // ch0 PASS on source 5 toggling every cycle
    n_sel[0 +: SEL_W] = 4'd5;
    for (int i = 0; i < 14; i++) begin
      n_src[5] = ~n_src[5];
      drive(1);
    end
    // ch1 STRETCH on source 3: single pulse, then retrigger 5 cycles apart
    n_sel[SEL_W +: SEL_W] = 4'd3; n_mode[2 +: 2] = 2'd3; n_src[3] = 1'b0;
    drive(6);
    n_src[3] = 1'b1; drive(1); n_src[3] = 1'b0; drive(12);
    n_src[3] = 1'b1; drive(1); n_src[3] = 1'b0; drive(4);
    n_src[3] = 1'b1; drive(1); n_src[3] = 1'b0; drive(16);
    // ch2 STICKY on source 7: set, clear after 10, then set/clear coincident
    n_sel[2*SEL_W +: SEL_W] = 4'd7; n_mode[4 +: 2] = 2'd2;
    drive(6);
    n_src[7] = 1'b1; drive(1); n_src[7] = 1'b0; drive(9);
    n_clr[2] = 1'b1; drive(1); n_clr[2] = 1'b0; drive(3);
    n_src[7] = 1'b1; n_clr[2] = 1'b1; drive(1);
    n_src[7] = 1'b0; n_clr[2] = 1'b0; drive(4);
    // ch0 out-of-range select 13 in PASS then REG
    n_sel[0 +: SEL_W] = 4'd13;
    for (int i = 0; i < 8; i++) begin n_src = NSRC'($urandom); drive(1); end
    n_mode[0 +: 2] = 2'd1;
    for (int i = 0; i < 8; i++) begin n_src = NSRC'($urandom); drive(1); end
    // ch0 REG on source 2, reset pulse during a ch1 stretch
    n_sel[0 +: SEL_W] = 4'd2; n_src = '0;
    drive(6);
    n_src[3] = 1'b1; drive(1); n_src[3] = 1'b0; drive(3);
    n_rst_n = 1'b0; drive(1); n_rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin n_src = NSRC'($urandom) & ~NSRC'(8); drive(1); end
    // ch0 select changes on consecutive cycles while ch1/ch2 stay active
    n_sel[0 +: SEL_W] = 4'd4; drive(1);
    n_sel[0 +: SEL_W] = 4'd6; drive(1);
    for (int i = 0; i < 12; i++) begin n_src = NSRC'($urandom); drive(1); end
    // randomized operation
    for (int i = 0; i < 2000; i++) begin
      n_src = NSRC'($urandom & $urandom);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 39) == 0) n_sel[c*SEL_W +: SEL_W] = SEL_W'($urandom_range(0, 15));
        if ($urandom_range(0, 59) == 0) n_mode[c*2 +: 2] = 2'($urandom_range(0, 3));
      end
      n_clr = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
      n_rst_n = ($urandom_range(0, 299) != 0);
      drive(1);
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
